// File: rtl/snn_config_commit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_config_commit_ctrl_if
// Purpose  : Bundles the signals between the configuration commit sequencer,
//            the SPI register file and the SNN core shadow-register port.
// Ports    : spi_done_async        - SPI instruction-done level (SCLK domain)
//            cfg_image             - NUM_BYTES configuration bytes, byte k at [8k+7:8k]
//            core_hold_ack         - core reports it is frozen (level)
//            core_hold             - freeze request to the core (level)
//            cfg_load/addr/byte    - one-byte shadow-register write strobe
//            commit_done           - one-cycle pulse, full image committed
//            commit_err            - sticky, hold/ack handshake timed out
//            busy                  - sequencer is not idle
//            master modport: the sequencer; slave modport: its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface snn_config_commit_ctrl_if #(
    parameter int NUM_BYTES = 113,
    parameter int ADDR_W    = 7
);
    logic                   spi_done_async;
    logic [NUM_BYTES*8-1:0] cfg_image;
    logic                   core_hold_ack;
    logic                   core_hold;
    logic                   cfg_load;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [7:0]             cfg_byte;
    logic                   commit_done;
    logic                   commit_err;
    logic                   busy;

    modport master (
        input  spi_done_async,
        input  cfg_image,
        input  core_hold_ack,
        output core_hold,
        output cfg_load,
        output cfg_addr,
        output cfg_byte,
        output commit_done,
        output commit_err,
        output busy
    );

    modport slave (
        output spi_done_async,
        output cfg_image,
        output core_hold_ack,
        input  core_hold,
        input  cfg_load,
        input  cfg_addr,
        input  cfg_byte,
        input  commit_done,
        input  commit_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/snn_config_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snn_config_commit_ctrl
// Purpose  : Core-clock sequencer that commits the SPI configuration image
//            into the SNN core. The SPI done level is synchronized, its rising
//            edge starts a commit: freeze the core (hold/ack), stream
//            NUM_BYTES bytes one per cycle, release and pulse commit_done.
//            A start arriving while busy is remembered and replayed once.
// Ports    : clk   - core clock
//            rst_n - asynchronous active-low reset
//            bus   - snn_config_commit_ctrl_if.master (see interface header)
// Revision : 1.0 - initial release
// ============================================================================
module snn_config_commit_ctrl #(
    parameter int NUM_BYTES   = 113,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    snn_config_commit_ctrl_if.master bus
);

    localparam int              c_TMR_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_REQ     = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_ABORT   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic                   r_pending;
    logic [c_TMR_W-1:0]     r_timer;
    logic                   r_cfg_load;
    logic [ADDR_W-1:0]      r_cfg_addr;
    logic [7:0]             r_cfg_byte;
    logic                   r_commit_done;
    logic                   r_commit_err;

    logic                   w_start;
    logic                   w_last_beat;
    logic                   w_timeout;
    logic [ADDR_W-1:0]      w_next_addr;
    logic [7:0]             w_next_byte;
    logic                   w_hold;
    logic                   w_busy;

    // ------------------------------------------------------------------
    // SPI done synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_sync_q <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.spi_done_async};
            r_sync_q <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_start     = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_last_beat = (r_cfg_addr == c_LAST_ADDR);
    assign w_timeout   = (r_timer == c_TMR_LAST);

    // r_cfg_addr always holds the address of the beat on the bus while in
    // LOAD, so the next beat is simply one above it; entry from REQ is 0.
    assign w_next_addr = (r_state == c_LOAD) ? (r_cfg_addr + ADDR_W'(1)) : '0;
    assign w_next_byte = bus.cfg_image[8*w_next_addr +: 8];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_hold       = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            c_IDLE: begin
                w_busy = 1'b0;
                if (w_start || r_pending) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                w_hold = 1'b1;
                // An ack on the final timer cycle still wins over the abort.
                if (bus.core_hold_ack) begin
                    w_next_state = c_LOAD;
                end else if (w_timeout) begin
                    w_next_state = c_ABORT;
                end
            end
            c_LOAD: begin
                // Ack is deliberately ignored here: once streaming starts the
                // image is always completed.
                w_hold = 1'b1;
                if (w_last_beat) begin
                    w_next_state = c_RELEASE;
                end
            end
            c_RELEASE: begin
                w_next_state = c_IDLE;
            end
            c_ABORT: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending start, ack timer and registered datapath outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= 1'b0;
            r_timer       <= '0;
            r_cfg_load    <= 1'b0;
            r_cfg_addr    <= '0;
            r_cfg_byte    <= 8'h00;
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
        end else begin
            // IDLE consumes the pending request (it moves to REQ whenever
            // pending is set); anywhere else a start is remembered, and
            // several starts collapse into one.
            if (r_state == c_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_start) begin
                r_pending <= 1'b1;
            end

            r_timer <= (r_state == c_REQ) ? (r_timer + c_TMR_W'(1)) : '0;

            // Outputs are loaded from the next state so that each LOAD cycle
            // carries its own beat and RELEASE carries commit_done.
            r_cfg_load    <= (w_next_state == c_LOAD);
            r_cfg_addr    <= (w_next_state == c_LOAD) ? w_next_addr : '0;
            r_cfg_byte    <= (w_next_state == c_LOAD) ? w_next_byte : 8'h00;
            r_commit_done <= (w_next_state == c_RELEASE);
            if (w_next_state == c_ABORT) begin
                r_commit_err <= 1'b1;
            end
        end
    end

    assign bus.core_hold   = w_hold;
    assign bus.busy        = w_busy;
    assign bus.cfg_load    = r_cfg_load;
    assign bus.cfg_addr    = r_cfg_addr;
    assign bus.cfg_byte    = r_cfg_byte;
    assign bus.commit_done = r_commit_done;
    assign bus.commit_err  = r_commit_err;

endmodule
`default_nettype wire

// File: tb/tb_snn_config_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_config_commit_ctrl
// Purpose  : Self-checking bench for snn_config_commit_ctrl. Random images and
//            ack delays; a transaction scoreboard expects every commit to be a
//            contiguous 0..NUM_BYTES-1 stream of the image bytes followed by a
//            single commit_done, and each scenario to yield a known number of
//            commits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_config_commit_ctrl;

    localparam int NUM_BYTES   = 113;
    localparam int ADDR_W      = 7;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_config_commit_ctrl_if #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) bus ();

    snn_config_commit_ctrl #(
        .NUM_BYTES  (NUM_BYTES),
        .ADDR_W     (ADDR_W),
        .SYNC_STAGES(SYNC_STAGES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NUM_BYTES*8-1:0] image;
    int  ack_delay    = 2;
    bit  ack_en       = 1'b1;
    int  hold_cnt     = 0;
    int  ack_rise_cyc = -1000;
    int  rise_cyc     = 0;

    // scoreboard state
    int  exp_addr    = 0;
    int  n_commits   = 0;
    int  n_beats     = 0;
    int  n_hold_rise = 0;
    bit  prev_load   = 1'b0;
    bit  prev_hold   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: acknowledges the freeze ack_delay cycles after hold rises,
    // drops ack as soon as hold drops.
    always @(negedge clk) begin
        if (!rst_n || !bus.core_hold) begin
            hold_cnt          = 0;
            bus.core_hold_ack = 1'b0;
        end else begin
            if (ack_en && !bus.core_hold_ack && hold_cnt >= ack_delay) begin
                bus.core_hold_ack = 1'b1;
                ack_rise_cyc      = cyc;
            end
            hold_cnt++;
        end
    end

    // Scoreboard: beat stream and commit framing.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            exp_addr  = 0;
            prev_load = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (bus.core_hold && !prev_hold) n_hold_rise++;
            if (bus.cfg_load) begin
                if (exp_addr == 0) check_val("ack_to_load", 64'(cyc - ack_rise_cyc), 64'd1);
                check_val("beat_addr", 64'(bus.cfg_addr), 64'(exp_addr));
                if (exp_addr < NUM_BYTES)
                    check_val("beat_byte", 64'(bus.cfg_byte), 64'(image[8*exp_addr +: 8]));
                else
                    check_val("beat_overrun", 64'(exp_addr), 64'(NUM_BYTES - 1));
                check_val("hold_in_load", 64'(bus.core_hold), 64'd1);
                check_val("done_in_load", 64'(bus.commit_done), 64'd0);
                exp_addr++;
                n_beats++;
            end else begin
                check_val("addr_idle", 64'(bus.cfg_addr), 64'd0);
                check_val("byte_idle", 64'(bus.cfg_byte), 64'd0);
                if (prev_load) begin
                    check_val("beat_count", 64'(exp_addr), 64'(NUM_BYTES));
                    check_val("done_after_last", 64'(bus.commit_done), 64'd1);
                    check_val("hold_at_release", 64'(bus.core_hold), 64'd0);
                    n_commits++;
                    exp_addr = 0;
                end else begin
                    check_val("done_stray", 64'(bus.commit_done), 64'd0);
                end
            end
            if (bus.core_hold) check_val("busy_with_hold", 64'(bus.busy), 64'd1);
            prev_load = bus.cfg_load;
            prev_hold = bus.core_hold;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_image();
        for (int i = 0; i < NUM_BYTES; i++) image[8*i +: 8] = 8'($urandom);
        bus.cfg_image = image;
    endtask

    task automatic spi_rise();
        @(negedge clk);
        bus.spi_done_async = 1'b1;
        rise_cyc           = cyc;
    endtask

    task automatic spi_fall();
        @(negedge clk);
        bus.spi_done_async = 1'b0;
    endtask

    task automatic wait_hold(output int at_cyc);
        int n;
        n      = 0;
        at_cyc = -1;
        while (n < 50) begin
            tick();
            if (bus.core_hold) begin
                at_cyc = cyc;
                break;
            end
            n++;
        end
        if (at_cyc < 0) check_val("hold_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_addr(input int a);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            tick();
            if (bus.cfg_load && bus.cfg_addr == ADDR_W'(a)) seen = 1'b1;
        end
        if (!seen) check_val("addr_wait_expired", 64'(a), 64'd0);
    endtask

    task automatic wait_quiet();
        int idle;
        idle = 0;
        for (int n = 0; n < 3000 && idle < 8; n++) begin
            tick();
            idle = bus.busy ? 0 : idle + 1;
        end
        if (idle < 8) check_val("quiet_wait_expired", 64'(idle), 64'd8);
    endtask

    // Commit with a second SPI edge landing at beat `at_addr`.
    task automatic run_double(input string tag, input int at_addr);
        int base_c, base_b, h;
        base_c = n_commits;
        base_b = n_beats;
        new_image();
        spi_rise();
        wait_hold(h);
        spi_fall();
        wait_addr(at_addr);
        @(negedge clk);
        bus.spi_done_async = 1'b1;
        wait_quiet();
        check_val({tag, "_commits"}, 64'(n_commits - base_c), 64'd2);
        check_val({tag, "_beats"}, 64'(n_beats - base_b), 64'(2 * NUM_BYTES));
        spi_fall();
    endtask

    initial begin
        int h, f, base_c, base_b, base_h;
        bus.spi_done_async = 1'b0;
        new_image();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hold", 64'(bus.core_hold), 64'd0);
        check_val("rst_load", 64'(bus.cfg_load), 64'd0);
        check_val("rst_addr", 64'(bus.cfg_addr), 64'd0);
        check_val("rst_byte", 64'(bus.cfg_byte), 64'd0);
        check_val("rst_done", 64'(bus.commit_done), 64'd0);
        check_val("rst_err", 64'(bus.commit_err), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();

        // 1: single commit, ack two cycles after hold
        ack_delay = 2;
        base_c    = n_commits;
        spi_rise();
        wait_hold(h);
        check_val("t1_hold_latency", 64'(h - rise_cyc), 64'(SYNC_STAGES + 1));
        wait_quiet();
        check_val("t1_commits", 64'(n_commits - base_c), 64'd1);
        check_val("t1_hold_after", 64'(bus.core_hold), 64'd0);
        check_val("t1_err", 64'(bus.commit_err), 64'd0);
        spi_fall();
        repeat (4) tick();

        // 2: second edge mid-load queues one more commit
        ack_delay = int'($urandom_range(0, 4));
        run_double("t2", 40);
        for (int k = 0; k < 3; k++) begin
            ack_delay = int'($urandom_range(0, 5));
            run_double("t2r", int'($urandom_range(5, 105)));
        end

        // 3: ack never arrives -> abort after ACK_TIMEOUT cycles of hold
        ack_en = 1'b0;
        base_c = n_commits;
        base_b = n_beats;
        spi_rise();
        wait_hold(h);
        f = -1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (!bus.core_hold) begin
                f = cyc;
                break;
            end
        end
        check_val("t3_hold_time", 64'(f - h), 64'(ACK_TIMEOUT));
        check_val("t3_err_set", 64'(bus.commit_err), 64'd1);
        spi_fall();
        wait_quiet();
        check_val("t3_no_commit", 64'(n_commits - base_c), 64'd0);
        check_val("t3_no_beats", 64'(n_beats - base_b), 64'd0);
        ack_en    = 1'b1;
        ack_delay = 1;
        new_image();
        spi_rise();
        wait_quiet();
        check_val("t3_commit_after", 64'(n_commits - base_c), 64'd1);
        check_val("t3_err_sticky", 64'(bus.commit_err), 64'd1);
        spi_fall();
        repeat (4) tick();

        // 4: reset in the middle of loading
        base_c = n_commits;
        new_image();
        spi_rise();
        wait_hold(h);
        spi_fall();
        wait_addr(60);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t4_hold", 64'(bus.core_hold), 64'd0);
        check_val("t4_load", 64'(bus.cfg_load), 64'd0);
        check_val("t4_addr", 64'(bus.cfg_addr), 64'd0);
        check_val("t4_byte", 64'(bus.cfg_byte), 64'd0);
        check_val("t4_done", 64'(bus.commit_done), 64'd0);
        check_val("t4_err", 64'(bus.commit_err), 64'd0);
        check_val("t4_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        base_h = n_hold_rise;
        repeat (200) tick();
        check_val("t4_no_restart", 64'(n_hold_rise - base_h), 64'd0);
        check_val("t4_no_commit", 64'(n_commits - base_c), 64'd0);

        // 5: edge lands on the release cycle -> exactly one extra commit
        ack_delay = int'($urandom_range(0, 4));
        run_double("t5", NUM_BYTES - 2);

        // 6: level held high for a long time -> one commit only
        base_c = n_commits;
        new_image();
        spi_rise();
        repeat (1000) tick();
        check_val("t6_commits_hi", 64'(n_commits - base_c), 64'd1);
        spi_fall();
        wait_quiet();
        check_val("t6_commits", 64'(n_commits - base_c), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
